// File: rtl/twiddle_pkg.sv
// Shared definitions for the twiddle bank loader: default width, W^0 constant,
// FSM state encoding and the flat-bus packing helper.
package twiddle_pkg;

  localparam int W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Largest positive Q1.(w-1) value, the closest representable stand-in for 1.0.
  function automatic int w0_coef(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int pack_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/twiddle_sumdiff.sv
// Registered sign-extend and sum/difference stage: (cos, sin) -> (c, cos+sin, cos-sin).
module twiddle_sumdiff
  import twiddle_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int AW = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vld_p0,
  input  logic [AW-1:0]        addr_p0,
  input  logic signed [W-1:0]  cos_p0,
  input  logic signed [W-1:0]  sin_p0,
  output logic                 vld_p1,
  output logic [AW-1:0]        addr_p1,
  output logic signed [W-1:0]  c_p1,
  output logic signed [W:0]    cps_p1,
  output logic signed [W:0]    cms_p1
);

  logic signed [W:0] cos_x;
  logic signed [W:0] sin_x;

  assign cos_x = {cos_p0[W-1], cos_p0};
  assign sin_x = {sin_p0[W-1], sin_p0};

  // p0 -> p1: one extra bit means the sum and difference can never overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    if (vld_p0) begin
      addr_p1 <= addr_p0;
      c_p1    <= cos_p0;
      cps_p1  <= cos_x + sin_x;
      cms_p1  <= cos_x - sin_x;
    end
  end

endmodule

// File: rtl/twiddle_bank_loader.sv
// Twiddle coefficient bank for one FFT stage, loaded from a (cos, sin) stream.
// Define TWIDDLE_DBUF_EN for active/shadow double buffering committed by swap.
module twiddle_bank_loader
  import twiddle_pkg::*;
#(
  parameter int N = 16,
  parameter int W = W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [W-1:0]      cos_in,
  input  logic signed [W-1:0]      sin_in,
  input  logic                     swap,
  output logic [N/2*W-1:0]         c_out,
  output logic [N/2*(W+1)-1:0]     cps_out,
  output logic [N/2*(W+1)-1:0]     cms_out,
  output logic                     bank_valid,
  output logic                     busy
);

  localparam int HN = N / 2;
  localparam int AW = $clog2(HN);
  localparam logic [AW-1:0]       LAST = AW'(HN - 1);
  localparam logic signed [W-1:0] C0   = W'(w0_coef(W));
  localparam logic signed [W:0]   S0   = (W+1)'(w0_coef(W));

  state_t              state;
  logic [AW-1:0]       addr;
  logic                beat;
  logic                start_ok;
  logic                vld_p1;
  logic [AW-1:0]       addr_p1;
  logic signed [W-1:0] c_p1;
  logic signed [W:0]   cps_p1;
  logic signed [W:0]   cms_p1;

  logic signed [W-1:0] c_rd   [HN];
  logic signed [W:0]   cps_rd [HN];
  logic signed [W:0]   cms_rd [HN];

  assign beat = in_valid && in_ready;

  twiddle_sumdiff #(.W(W), .AW(AW)) u_sumdiff (
    .clk     (clk),
    .rst_n   (rst_n),
    .vld_p0  (beat),
    .addr_p0 (addr),
    .cos_p0  (cos_in),
    .sin_p0  (sin_in),
    .vld_p1  (vld_p1),
    .addr_p1 (addr_p1),
    .c_p1    (c_p1),
    .cps_p1  (cps_p1),
    .cms_p1  (cms_p1)
  );

`ifdef TWIDDLE_DBUF_EN
  logic sel;
  logic swap_pending;
  logic signed [W-1:0] c_bank   [2][HN];
  logic signed [W:0]   cps_bank [2][HN];
  logic signed [W:0]   cms_bank [2][HN];

  // A finished set must not be replaced by a new load until it has been swapped in.
  assign start_ok = start && !swap_pending;

  // p1 -> bank: loads always land in the shadow half
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < HN; k++) begin
          c_bank[b][k]   <= '0;
          cps_bank[b][k] <= '0;
          cms_bank[b][k] <= '0;
        end
      end
    end else if (vld_p1) begin
      c_bank[~sel][addr_p1]   <= c_p1;
      cps_bank[~sel][addr_p1] <= cps_p1;
      cms_bank[~sel][addr_p1] <= cms_p1;
    end
  end

  always_comb begin
    for (int k = 0; k < HN; k++) begin
      c_rd[k]   = c_bank[sel][k];
      cps_rd[k] = cps_bank[sel][k];
      cms_rd[k] = cms_bank[sel][k];
    end
  end
`else
  logic signed [W-1:0] c_bank   [HN];
  logic signed [W:0]   cps_bank [HN];
  logic signed [W:0]   cms_bank [HN];
  logic                unused_swap;

  assign unused_swap = swap;
  assign start_ok    = start;

  // p1 -> bank: writes go straight to the visible bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < HN; k++) begin
        c_bank[k]   <= '0;
        cps_bank[k] <= '0;
        cms_bank[k] <= '0;
      end
    end else if (vld_p1) begin
      c_bank[addr_p1]   <= c_p1;
      cps_bank[addr_p1] <= cps_p1;
      cms_bank[addr_p1] <= cms_p1;
    end
  end

  assign c_rd   = c_bank;
  assign cps_rd = cps_bank;
  assign cms_rd = cms_bank;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr       <= AW'(1);
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      bank_valid <= 1'b0;
`ifdef TWIDDLE_DBUF_EN
      sel          <= 1'b0;
      swap_pending <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            state    <= LOAD;
            addr     <= AW'(1);
            in_ready <= 1'b1;
            busy     <= 1'b1;
`ifndef TWIDDLE_DBUF_EN
            bank_valid <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (beat) begin
            addr <= addr + AW'(1);
            if (addr == LAST) begin
              state    <= FLUSH;
              in_ready <= 1'b0;
            end
          end
        end
        FLUSH: begin
          // The last entry is written on this same edge by the p1 stage.
          state <= DONE;
          busy  <= 1'b0;
`ifdef TWIDDLE_DBUF_EN
          if (!bank_valid) begin
            sel        <= ~sel;
            bank_valid <= 1'b1;
          end else begin
            swap_pending <= 1'b1;
          end
`else
          bank_valid <= 1'b1;
`endif
        end
      endcase
`ifdef TWIDDLE_DBUF_EN
      if (swap && swap_pending) begin
        sel          <= ~sel;
        swap_pending <= 1'b0;
      end
`endif
    end
  end

  for (genvar k = 0; k < HN; k++) begin : g_pack
    if (k == 0) begin : g_w0
      assign c_out[pack_lsb(k, W) +: W]           = C0;
      assign cps_out[pack_lsb(k, W + 1) +: W + 1] = S0;
      assign cms_out[pack_lsb(k, W + 1) +: W + 1] = S0;
    end else begin : g_ent
      assign c_out[pack_lsb(k, W) +: W]           = c_rd[k];
      assign cps_out[pack_lsb(k, W + 1) +: W + 1] = cps_rd[k];
      assign cms_out[pack_lsb(k, W + 1) +: W + 1] = cms_rd[k];
    end
  end

endmodule

// File: tb/tb_twiddle_bank_loader.sv
// Self-checking bench for twiddle_bank_loader (N=16, W=8): spec-level model compared
// every cycle, plus hand-computed literal expectations.
module tb_twiddle_bank_loader;

  localparam int N  = 16;
  localparam int W  = 8;
  localparam int HN = N / 2;
`ifdef TWIDDLE_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        swap = 1'b0;
  logic [7:0]  cos_in = 8'h00;
  logic [7:0]  sin_in = 8'h00;
  logic        in_ready, bank_valid, busy;
  logic [63:0] c_out;
  logic [71:0] cps_out, cms_out;

  twiddle_bank_loader #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .cos_in     (cos_in),
    .sin_in     (sin_in),
    .swap       (swap),
    .c_out      (c_out),
    .cps_out    (cps_out),
    .cms_out    (cms_out),
    .bank_valid (bank_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit checking = 1'b0;

  logic [7:0] ld_cos [1:7];
  logic [7:0] ld_sin [1:7];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Model: phase 0 idle, 1 loading, 2 flushing, 3 done.
  int         m_phase, m_next, m_sel;
  bit         m_valid, m_pend_swap, p_vld;
  int         p_addr;
  logic [7:0] p_cos, p_sin;
  logic [7:0] m_c   [2][8];
  logic [8:0] m_cps [2][8];
  logic [8:0] m_cms [2][8];

  task automatic model_reset();
    m_phase = 0; m_next = 1; m_sel = 0;
    m_valid = 1'b0; m_pend_swap = 1'b0; p_vld = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < 8; k++) begin
        m_c[b][k] = '0; m_cps[b][k] = '0; m_cms[b][k] = '0;
      end
  endtask

  task automatic model_step();
    int wr, s, d;
    bit sw;
    wr = DBUF ? 1 - m_sel : 0;
    if (p_vld) begin
      s = $signed(p_cos) + $signed(p_sin);
      d = $signed(p_cos) - $signed(p_sin);
      m_c[wr][p_addr]   = p_cos;
      m_cps[wr][p_addr] = 9'(s);
      m_cms[wr][p_addr] = 9'(d);
    end
    p_vld = 1'b0;
    sw = DBUF && swap && m_pend_swap;
    case (m_phase)
      0, 3: if (start && !(DBUF && m_pend_swap)) begin
        m_phase = 1; m_next = 1;
        if (!DBUF) m_valid = 1'b0;
      end
      1: if (in_valid) begin
        p_vld = 1'b1; p_addr = m_next; p_cos = cos_in; p_sin = sin_in;
        if (m_next == HN - 1) m_phase = 2;
        m_next++;
      end
      2: begin
        m_phase = 3;
        if (!DBUF) m_valid = 1'b1;
        else if (!m_valid) begin m_sel = 1 - m_sel; m_valid = 1'b1; end
        else m_pend_swap = 1'b1;
      end
      default: m_phase = 0;
    endcase
    if (sw) begin m_sel = 1 - m_sel; m_pend_swap = 1'b0; end
  endtask

  always @(negedge rst_n) model_reset();
  always @(posedge clk) if (rst_n) model_step();

  always @(negedge clk) begin
    if (checking) begin
      logic [63:0] ec;
      logic [71:0] ep, em;
      int rd;
      rd = DBUF ? m_sel : 0;
      ec[7:0] = 8'h7F; ep[8:0] = 9'h07F; em[8:0] = 9'h07F;
      for (int k = 1; k < 8; k++) begin
        ec[k*8 +: 8] = m_c[rd][k];
        ep[k*9 +: 9] = m_cps[rd][k];
        em[k*9 +: 9] = m_cms[rd][k];
      end
      check("c_out", c_out, ec);
      check("cps_out", cps_out, ep);
      check("cms_out", cms_out, em);
      check("bank_valid", bank_valid, m_valid);
      check("in_ready", in_ready, m_phase == 1);
      check("busy", busy, m_phase == 1 || m_phase == 2);
    end
  end

  task automatic do_load(input bit gappy, input int nb);
    int b = 1;
    int cyc = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (b <= nb && cyc < 100) begin
      if (!gappy || (cyc % 3) == 0) begin
        in_valid = 1'b1; cos_in = ld_cos[b]; sin_in = ld_sin[b]; b++;
      end else begin
        in_valid = 1'b0; cos_in = 8'(cyc * 37); sin_in = 8'(~cyc);
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i = 0;
    while (busy === 1'b1 && i < 20) begin @(negedge clk); i++; end
    check("idle_timeout", busy, 1'b0);
  endtask

  initial begin
    // Reset asserted mid-cycle: outputs must change immediately.
    #3 rst_n = 1'b0;
    #1;
    check("rst_bank_valid", bank_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_c0", c_out[7:0], 8'h7F);
    check("rst_cps0", cps_out[8:0], 9'h07F);
    check("rst_c_rest", c_out[63:8], 56'h0);
    check("rst_cms_rest", cms_out[71:9], 63'h0);
    checking = 1'b1;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;

    // Full back-to-back load (set A).
    ld_cos = '{8'h76, 8'h5A, 8'h31, 8'h00, 8'hCF, 8'hA6, 8'h8A};
    ld_sin = '{8'hCF, 8'hA6, 8'h8A, 8'h81, 8'h8A, 8'hA6, 8'hCF};
    do_load(1'b0, 7);
    check("flush_busy", busy, 1'b1);
    check("flush_in_ready", in_ready, 1'b0);
    check("flush_bank_valid", bank_valid, 1'b0);
    @(negedge clk);
    check("done_bank_valid", bank_valid, 1'b1);
    check("done_busy", busy, 1'b0);
    check("a_c2", c_out[23:16], 8'h5A);
    check("a_cps2", cps_out[26:18], 9'h000);
    check("a_cms2", cms_out[26:18], 9'h0B4);
    check("a_c7", c_out[63:56], 8'h8A);

    // Gapped load with sign extremes (set B), then late data.
    ld_cos = '{8'h80, 8'h7F, 8'h10, 8'hF0, 8'h01, 8'hFF, 8'h40};
    ld_sin = '{8'h80, 8'h80, 8'h20, 8'hE0, 8'h7F, 8'h01, 8'hC0};
    do_load(1'b1, 7);
    wait_idle();
    in_valid = 1'b1; cos_in = 8'h55; sin_in = 8'h55;
    repeat (3) begin
      @(negedge clk);
      check("late_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
`ifdef TWIDDLE_DBUF_EN
    check("dbuf_hold_c2", c_out[23:16], 8'h5A);
    check("dbuf_hold_valid", bank_valid, 1'b1);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("start_ignored", busy, 1'b0);
    swap = 1'b1;
    @(negedge clk); swap = 1'b0;
    check("swap_visible", c_out[15:8], 8'h80);
`else
    swap = 1'b1;
    @(negedge clk); swap = 1'b0;
    @(negedge clk);
`endif
    check("b_cps1", cps_out[17:9], 9'h100);
    check("b_cms1", cms_out[17:9], 9'h000);
    check("b_cps2", cps_out[26:18], 9'h1FF);
    check("b_cms2", cms_out[26:18], 9'h0FF);

    // Reset after three beats, then a fresh load (set C).
    for (int k = 1; k <= 7; k++) begin
      ld_cos[k] = 8'(k * 16 + 1);
      ld_sin[k] = 8'(8'hF0 - k);
    end
    do_load(1'b0, 3);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bank_valid, 1'b0);
    check("mid_rst_ready", in_ready, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_c_rest", c_out[63:8], 56'h0);
    @(negedge clk); rst_n = 1'b1;
    do_load(1'b0, 7);
    @(negedge clk);
    wait_idle();
    check("c_c1", c_out[15:8], 8'h11);
    check("c_cps1", cps_out[17:9], 9'h000);
    check("c_cms1", cms_out[17:9], 9'h022);
    check("c_valid", bank_valid, 1'b1);

    @(negedge clk);
    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
